// File: rtl/spi_word_framer.sv
// Word/byte framing between the SPI byte driver and the PU word buffers.
// TX words are sliced MSB-first into bytes; received bytes are packed back into words.
module spi_word_framer #(
   parameter int DATA_WIDTH     = 32,
   parameter int SPI_DATA_WIDTH = 8,
   parameter int BUF_SIZE       = 6,
   localparam int CNT_W         = $clog2(BUF_SIZE + 1)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clear,
   input  logic                      wr,
   input  logic [DATA_WIDTH-1:0]     data_in,
   input  logic                      oe,
   output logic [DATA_WIDTH-1:0]     data_out,
   output logic [CNT_W-1:0]          tx_count,
   output logic [CNT_W-1:0]          rx_count,
   output logic                      tx_underflow,
   output logic                      rx_overflow,
   output logic                      frame_done,
   input  logic                      byte_strobe,
   input  logic [SPI_DATA_WIDTH-1:0] spi_byte_in,
   output logic [SPI_DATA_WIDTH-1:0] spi_byte_out,
   input  logic                      cs
);

   localparam int NB    = DATA_WIDTH / SPI_DATA_WIDTH;
   localparam int SH_W  = DATA_WIDTH - SPI_DATA_WIDTH;
   localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
   localparam int PTR_W = (BUF_SIZE > 1) ? $clog2(BUF_SIZE) : 1;
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUF_SIZE - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NB - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BUF_SIZE);

   logic [DATA_WIDTH-1:0] tx_mem_q [BUF_SIZE];
   logic [DATA_WIDTH-1:0] rx_mem_q [BUF_SIZE];

   logic [PTR_W-1:0] tx_rd_q, tx_rd_d, tx_wr_q, tx_wr_d;
   logic [PTR_W-1:0] rx_rd_q, rx_rd_d, rx_wr_q, rx_wr_d;
   logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
   logic [IDX_W-1:0] byte_idx_q, byte_idx_d;
   logic [SH_W-1:0]  rx_shift_q, rx_shift_d;
   logic             tx_underflow_q, tx_underflow_d;
   logic             rx_overflow_q, rx_overflow_d;
   logic             cs_q, frame_done_q;

   logic                  flush, strobe_v, cs_rise, word_done;
   logic                  tx_pop, tx_push, rx_pop, rx_push;
   logic [DATA_WIDTH-1:0] rx_word, tx_head;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
   endfunction

   assign flush     = rst | clear;
   assign strobe_v  = byte_strobe & ~cs;
   assign cs_rise   = cs & ~cs_q;
   assign word_done = strobe_v && (byte_idx_q == IDX_LAST);
   assign rx_word   = {rx_shift_q, spi_byte_in};

   // A full queue still accepts when it frees a slot in the same cycle.
   assign tx_pop  = word_done && (tx_cnt_q != '0);
   assign tx_push = wr && ((tx_cnt_q != CNT_FULL) || tx_pop);
   assign rx_pop  = oe && (rx_cnt_q != '0);
   assign rx_push = word_done && ((rx_cnt_q != CNT_FULL) || rx_pop);

   always_comb begin
      byte_idx_d     = byte_idx_q;
      rx_shift_d     = rx_shift_q;
      tx_underflow_d = tx_underflow_q;
      rx_overflow_d  = rx_overflow_q;
      tx_rd_d        = tx_pop  ? ptr_inc(tx_rd_q) : tx_rd_q;
      tx_wr_d        = tx_push ? ptr_inc(tx_wr_q) : tx_wr_q;
      rx_rd_d        = rx_pop  ? ptr_inc(rx_rd_q) : rx_rd_q;
      rx_wr_d        = rx_push ? ptr_inc(rx_wr_q) : rx_wr_q;
      tx_cnt_d       = tx_cnt_q + CNT_W'(tx_push) - CNT_W'(tx_pop);
      rx_cnt_d       = rx_cnt_q + CNT_W'(rx_push) - CNT_W'(rx_pop);
      if (strobe_v) begin
         rx_shift_d = rx_word[SH_W-1:0];
         byte_idx_d = word_done ? '0 : byte_idx_q + IDX_W'(1);
      end
      if (cs_rise) begin
         byte_idx_d = '0;
         rx_shift_d = '0;
      end
      if (word_done && !tx_pop)  tx_underflow_d = 1'b1;
      if (word_done && !rx_push) rx_overflow_d  = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (flush) begin
         tx_rd_q        <= '0;
         tx_wr_q        <= '0;
         rx_rd_q        <= '0;
         rx_wr_q        <= '0;
         tx_cnt_q       <= '0;
         rx_cnt_q       <= '0;
         byte_idx_q     <= '0;
         rx_shift_q     <= '0;
         tx_underflow_q <= 1'b0;
         rx_overflow_q  <= 1'b0;
         cs_q           <= 1'b1;
         frame_done_q   <= 1'b0;
      end else begin
         tx_rd_q        <= tx_rd_d;
         tx_wr_q        <= tx_wr_d;
         rx_rd_q        <= rx_rd_d;
         rx_wr_q        <= rx_wr_d;
         tx_cnt_q       <= tx_cnt_d;
         rx_cnt_q       <= rx_cnt_d;
         byte_idx_q     <= byte_idx_d;
         rx_shift_q     <= rx_shift_d;
         tx_underflow_q <= tx_underflow_d;
         rx_overflow_q  <= rx_overflow_d;
         cs_q           <= cs;
         frame_done_q   <= cs_rise;
      end
   end

   always_ff @(posedge clk) begin
      if (tx_push && !flush) tx_mem_q[tx_wr_q] <= data_in;
      if (rx_push && !flush) rx_mem_q[rx_wr_q] <= rx_word;
   end

   assign tx_head      = tx_mem_q[tx_rd_q];
   assign spi_byte_out = (tx_cnt_q != '0)
                         ? tx_head[(DATA_WIDTH-1) - int'(byte_idx_q)*SPI_DATA_WIDTH -: SPI_DATA_WIDTH]
                         : '0;
   assign data_out     = (rx_cnt_q != '0) ? rx_mem_q[rx_rd_q] : '0;
   assign tx_count     = tx_cnt_q;
   assign rx_count     = rx_cnt_q;
   assign tx_underflow = tx_underflow_q;
   assign rx_overflow  = rx_overflow_q;
   assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_spi_word_framer.sv
// Bench for spi_word_framer: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_spi_word_framer;
   localparam int BUF = 6;
   localparam int NB  = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1, clear = 1'b0, wr = 1'b0, oe = 1'b0;
   logic        byte_strobe = 1'b0, cs = 1'b1;
   logic [31:0] data_in = '0;
   logic [7:0]  spi_byte_in = '0;
   logic [31:0] data_out;
   logic [2:0]  tx_count, rx_count;
   logic        tx_underflow, rx_overflow, frame_done;
   logic [7:0]  spi_byte_out;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en   = 1'b0;

   always #5 clk = ~clk;

   spi_word_framer dut (
      .clk(clk), .rst(rst), .clear(clear), .wr(wr), .data_in(data_in), .oe(oe),
      .data_out(data_out), .tx_count(tx_count), .rx_count(rx_count),
      .tx_underflow(tx_underflow), .rx_overflow(rx_overflow), .frame_done(frame_done),
      .byte_strobe(byte_strobe), .spi_byte_in(spi_byte_in), .spi_byte_out(spi_byte_out),
      .cs(cs)
   );

   // Reference model: words in flight are queues, the current frame's bytes are a byte list.
   logic [31:0] m_tx[$];
   logic [31:0] m_rx[$];
   logic [7:0]  m_part[$];
   logic        m_txu = 1'b0, m_rxo = 1'b0, m_fd = 1'b0, m_csp = 1'b1;
   logic        m_wd, m_rxpop;
   logic [31:0] m_w;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      if (rst || clear) begin
         m_tx.delete(); m_rx.delete(); m_part.delete();
         m_txu = 1'b0; m_rxo = 1'b0; m_fd = 1'b0; m_csp = 1'b1;
      end else begin
         m_wd     = 1'b0;
         m_rxpop  = oe && (m_rx.size() > 0);
         m_fd     = cs && !m_csp;
         m_csp    = cs;
         if (m_fd) m_part.delete();
         else if (byte_strobe && !cs) begin
            m_part.push_back(spi_byte_in);
            if (m_part.size() == NB) begin
               m_wd = 1'b1;
               m_w  = '0;
               foreach (m_part[i]) m_w = (m_w << 8) | 32'(m_part[i]);
               m_part.delete();
            end
         end
         if (m_rxpop) void'(m_rx.pop_front());
         if (m_wd) begin
            if (m_rx.size() < BUF) m_rx.push_back(m_w);
            else m_rxo = 1'b1;
            if (m_tx.size() > 0) void'(m_tx.pop_front());
            else m_txu = 1'b1;
         end
         if (wr && m_tx.size() < BUF) m_tx.push_back(data_in);
      end
   end

   always @(negedge clk) begin
      logic [31:0] h;
      logic [7:0]  eb;
      int          k;
      if (chk_en) begin
         eb = '0;
         if (m_tx.size() > 0) begin
            h  = m_tx[0];
            k  = m_part.size();
            eb = h[31 - 8*k -: 8];
         end
         check("model spi_byte_out", 32'(spi_byte_out), 32'(eb));
         check("model data_out", data_out, (m_rx.size() > 0) ? m_rx[0] : 32'h0);
         check("model tx_count", 32'(tx_count), 32'(m_tx.size()));
         check("model rx_count", 32'(rx_count), 32'(m_rx.size()));
         check("model tx_underflow", 32'(tx_underflow), 32'(m_txu));
         check("model rx_overflow", 32'(rx_overflow), 32'(m_rxo));
         check("model frame_done", 32'(frame_done), 32'(m_fd));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      wr = 1'b0; oe = 1'b0; byte_strobe = 1'b0; rst = 1'b0; clear = 1'b0;
   endtask

   task automatic strobe(input logic [7:0] b);
      byte_strobe = 1'b1;
      spi_byte_in = b;
      tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
   endtask

   initial begin
      logic [7:0] exp_b [4];
      int wr_pct, oe_pct;

      tick();
      chk_en = 1'b1;
      check("reset data_out", data_out, 32'h0);
      check("reset spi_byte_out", 32'(spi_byte_out), 32'h0);
      check("reset tx_count", 32'(tx_count), 32'h0);
      check("reset rx_count", 32'(rx_count), 32'h0);

      // Basic word out / word in
      do_reset();
      wr = 1'b1; data_in = 32'hA1B2C3D4; tick();
      cs = 1'b0; tick();
      exp_b = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
      for (int k = 0; k < 4; k++) begin
         check("t1 byte out", 32'(spi_byte_out), 32'(exp_b[k]));
         strobe(8'(8'h11 * (k + 1)));
      end
      check("t1 data_out", data_out, 32'h11223344);
      check("t1 rx_count", 32'(rx_count), 32'd1);
      check("t1 tx_count", 32'(tx_count), 32'd0);

      // TX full handling
      do_reset();
      for (int i = 0; i < 6; i++) begin
         wr = 1'b1; data_in = $urandom; tick();
      end
      wr = 1'b1; data_in = 32'hFFFF0000; tick();
      check("t2 tx full ignore", 32'(tx_count), 32'd6);
      for (int k = 0; k < 3; k++) strobe(8'(k));
      wr = 1'b1; data_in = 32'h12345678; strobe(8'h03);
      check("t2 tx full with pop", 32'(tx_count), 32'd6);

      // RX overflow and pop-on-full
      do_reset();
      for (int w = 0; w < 7; w++)
         for (int j = 0; j < 4; j++) strobe(8'(w*4 + j));
      check("t3 rx_count full", 32'(rx_count), 32'd6);
      check("t3 rx_overflow", 32'(rx_overflow), 32'd1);
      check("t3 data_out head", data_out, 32'h00010203);
      do_reset();
      for (int w = 0; w < 7; w++)
         for (int j = 0; j < 4; j++) begin
            if (w == 6 && j == 3) oe = 1'b1;
            strobe(8'(w*4 + j));
         end
      check("t3 no overflow", 32'(rx_overflow), 32'd0);
      check("t3 rx_count pop+push", 32'(rx_count), 32'd6);
      check("t3 data_out second", data_out, 32'h04050607);

      // Aborted frame: TX head resent, partial RX dropped
      cs = 1'b1;
      do_reset();
      wr = 1'b1; data_in = 32'hDEADBEEF; tick();
      cs = 1'b0;
      strobe(8'hAA); strobe(8'hBB);
      cs = 1'b1; tick();
      check("t4 frame_done", 32'(frame_done), 32'd1);
      check("t4 tx_count", 32'(tx_count), 32'd1);
      cs = 1'b0;
      exp_b = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      for (int k = 0; k < 4; k++) begin
         check("t4 resend byte", 32'(spi_byte_out), 32'(exp_b[k]));
         strobe(8'(8'h10 + k));
      end
      check("t4 rx_count", 32'(rx_count), 32'd1);
      check("t4 data_out", data_out, 32'h10111213);

      // Underflow and clear
      do_reset();
      for (int k = 0; k < 4; k++) begin
         check("t5 empty byte", 32'(spi_byte_out), 32'h0);
         strobe(8'(8'h40 + k));
      end
      check("t5 tx_underflow", 32'(tx_underflow), 32'd1);
      clear = 1'b1; tick();
      check("t5 clr underflow", 32'(tx_underflow), 32'd0);
      check("t5 clr overflow", 32'(rx_overflow), 32'd0);
      check("t5 clr tx_count", 32'(tx_count), 32'd0);
      check("t5 clr rx_count", 32'(rx_count), 32'd0);

      // Reset mid-word
      do_reset();
      wr = 1'b1; data_in = 32'h01020304; tick();
      strobe(8'h99); strobe(8'h98);
      do_reset();
      check("t6 data_out", data_out, 32'h0);
      check("t6 spi_byte_out", 32'(spi_byte_out), 32'h0);
      check("t6 tx_count", 32'(tx_count), 32'd0);
      check("t6 rx_count", 32'(rx_count), 32'd0);
      exp_b = '{8'h5A, 8'h6B, 8'h7C, 8'h8D};
      for (int k = 0; k < 4; k++) strobe(exp_b[k]);
      check("t6 data_out word", data_out, 32'h5A6B7C8D);
      check("t6 rx_count word", 32'(rx_count), 32'd1);

      // Randomized traffic with shifting push/pop pressure
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         case ((i / 500) % 4)
            0: begin wr_pct = 30; oe_pct = 30; end
            1: begin wr_pct = 80; oe_pct = 5;  end
            2: begin wr_pct = 5;  oe_pct = 80; end
            default: begin wr_pct = 50; oe_pct = 50; end
         endcase
         if (cs) begin
            if ($urandom_range(0, 3) == 0) cs = 1'b0;
         end else if ($urandom_range(0, 39) == 0) cs = 1'b1;
         byte_strobe = 1'($urandom_range(0, 1));
         spi_byte_in = 8'($urandom);
         wr          = ($urandom_range(0, 99) < wr_pct);
         data_in     = $urandom;
         oe          = ($urandom_range(0, 99) < oe_pct);
         rst         = ($urandom_range(0, 999) == 0);
         clear       = ($urandom_range(0, 799) == 0);
         tick();
      end

      @(negedge clk);
      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
